result_display_driver: RTL and testbench

//  Downstream consumer of the exponent engine's 32-bit result p. Takes one result per

---
 rtl/result_display_driver_pkg.sv | 48 ++++
 rtl/result_display_driver_if.sv | 26 ++
 rtl/result_display_driver_seg7_decode.sv | 13 +
 rtl/result_display_driver.sv | 154 +++++++++++++++
 tb/tb_result_display_driver.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/result_display_driver_pkg.sv
// Shared types and helpers for the result display driver.
//   state_t      : FSM encoding (IDLE, CONVERT, LOAD)
//   SEG_BLANK    : all segments off (active-low)
//   SEG_DASH     : only segment g lit, used to flag overflow
//   seg_of()     : BCD digit -> active-low {g,f,e,d,c,b,a} pattern
//   add3_if_ge5(): double-dabble digit correction step
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Values above 9 never come out of a correct conversion; show them blank.
  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // A digit >= 5 would become >= 10 after the next shift, so pre-correct it.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] digit);
    logic [3:0] res;
    if (digit >= 4'd5) begin
      res = digit + 4'd3;
    end else begin
      res = digit;
    end
    return res;
  endfunction

endpackage

// File: rtl/result_display_driver_if.sv
// Valid/ready input channel carrying the binary result to display.
//   in_valid : producer has a value this cycle
//   in_data  : unsigned binary value, WIDTH bits
//   in_ready : consumer can take the value this cycle
// master = producer side, slave = the display driver.
interface result_display_driver_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/result_display_driver_seg7_decode.sv
// Combinational single-digit seven-segment decoder.
//   digit : 4-bit BCD digit
//   seg   : active-low segments {g,f,e,d,c,b,a}; blank for digits above 9
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = seg_of(digit);

endmodule

// File: rtl/result_display_driver.sv
// Result display driver: accepts one binary value per valid/ready handshake,
// converts it to BCD with a one-shift-per-clock double-dabble, and drives six
// active-low seven-segment digits with leading-zero blanking and an overflow
// indication (all dashes) when the value needs more than SHOW_DIGITS digits.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   in_if     : slave side of the valid/ready input channel
//   bcd       : last converted value, digit 0 in bits [3:0]
//   hex0..5   : active-low segments, hex0 least significant
//   overflow  : last value has a nonzero digit at index >= SHOW_DIGITS
//   busy      : conversion in progress
// All display outputs are registered and only change in LOAD, so nothing
// flickers while a conversion is running.
module result_display_driver
  import display_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 10,
  parameter int SHOW_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  result_display_driver_if.slave  in_if,
  output logic [4*DIGITS-1:0]     bcd,
  output logic [6:0]              hex0,
  output logic [6:0]              hex1,
  output logic [6:0]              hex2,
  output logic [6:0]              hex3,
  output logic [6:0]              hex4,
  output logic [6:0]              hex5,
  output logic                    overflow,
  output logic                    busy
);

  localparam int              ACC_W    = 4 * DIGITS;
  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_adj_s;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] bcd_r;
  logic             overflow_r;
  logic [6:0]       hex_r  [SHOW_DIGITS];
  logic [6:0]       seg_s  [SHOW_DIGITS];
  logic [6:0]       disp_s [SHOW_DIGITS];
  logic             ovf_s;
  logic             nz_s;

  // Handshake status is a pure decode of the state register.
  assign in_if.in_ready = (state_r == IDLE);
  assign busy           = (state_r != IDLE);

  assign bcd      = bcd_r;
  assign overflow = overflow_r;
  assign hex0     = hex_r[0];
  assign hex1     = hex_r[1];
  assign hex2     = hex_r[2];
  assign hex3     = hex_r[3];
  assign hex4     = hex_r[4];
  assign hex5     = hex_r[5];

  // One decoder per displayed digit, fed from the accumulator so the patterns
  // are ready when LOAD registers them.
  for (genvar g = 0; g < SHOW_DIGITS; g++) begin : g_seg
    seg7_decode u_seg7_decode (
      .digit (acc_r[4*g +: 4]),
      .seg   (seg_s[g])
    );
  end

  // Double-dabble correction: each 4-bit digit independently, no inter-digit carry.
  always_comb begin
    acc_adj_s = '0;
    for (int d = 0; d < DIGITS; d++) begin
      acc_adj_s[4*d +: 4] = add3_if_ge5(acc_r[4*d +: 4]);
    end
  end

  // Display selection: dashes on overflow, otherwise blank leading zeros above
  // the highest nonzero digit (hex0 is always shown so 0 reads as "0").
  always_comb begin
    ovf_s = |acc_r[ACC_W-1:4*SHOW_DIGITS];
    nz_s  = 1'b0;
    for (int i = 0; i < SHOW_DIGITS; i++) begin
      disp_s[i] = SEG_BLANK;
    end
    for (int i = SHOW_DIGITS - 1; i >= 0; i--) begin
      nz_s = nz_s | (acc_r[4*i +: 4] != 4'd0);
      if (ovf_s) begin
        disp_s[i] = SEG_DASH;
      end else if (nz_s || (i == 0)) begin
        disp_s[i] = seg_s[i];
      end else begin
        disp_s[i] = SEG_BLANK;
      end
    end
  end

  // Control FSM plus conversion datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      acc_r      <= '0;
      cnt_r      <= '0;
      bcd_r      <= '0;
      overflow_r <= 1'b0;
      for (int i = 0; i < SHOW_DIGITS; i++) begin
        hex_r[i] <= SEG_BLANK;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_if.in_valid) begin
            shreg_r <= in_if.in_data;
            acc_r   <= '0;
            cnt_r   <= '0;
            state_r <= CONVERT;
          end else begin
            state_r <= IDLE;
          end
        end
        CONVERT: begin
          // Shift {acc,shreg} left by one after correction; the bit leaving
          // the top of acc is always zero when DIGITS is large enough.
          acc_r   <= ACC_W'({acc_adj_s, shreg_r[WIDTH-1]});
          shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= LOAD;
          end else begin
            state_r <= CONVERT;
          end
        end
        LOAD: begin
          bcd_r      <= acc_r;
          overflow_r <= ovf_s;
          for (int i = 0; i < SHOW_DIGITS; i++) begin
            hex_r[i] <= disp_s[i];
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_display_driver.sv
// Scoreboard bench for result_display_driver: the driver pushes hand-computed
// expectations when it issues a value; the monitor pops and compares whenever
// the DUT finishes a conversion (busy falling without reset).
module tb_result_display_driver;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [39:0] bcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        overflow;
  logic        busy;

  result_display_driver_if #(.WIDTH(32)) in_if ();

  result_display_driver #(
    .WIDTH       (32),
    .DIGITS      (10),
    .SHOW_DIGITS (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_if    (in_if),
    .bcd      (bcd),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] bcd;
    logic [41:0] hex;
    logic        ovf;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  int          tests_run = 0;
  int          fails     = 0;
  int unsigned cyc       = 0;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] DS = 7'h3F;
  localparam logic [41:0] ALL_BLANK = {BL, BL, BL, BL, BL, BL};
  localparam logic [41:0] ALL_DASH  = {DS, DS, DS, DS, DS, DS};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [41:0] hx(input logic [6:0] h5, input logic [6:0] h4,
                                     input logic [6:0] h3, input logic [6:0] h2,
                                     input logic [6:0] h1, input logic [6:0] h0);
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  // Called at the negedge before the accepting posedge: outputs appear 34
  // posedges later, seen at the following negedge.
  task automatic push_exp(input logic [39:0] eb, input logic [41:0] eh, input logic eo);
    exp_t e;
    e.bcd = eb;
    e.hex = eh;
    e.ovf = eo;
    e.due = cyc + 34;
    sb_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_if.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(in_if.in_ready), 64'd1);
  endtask

  task automatic send(input logic [31:0] v, input logic [39:0] eb, input logic [41:0] eh,
                      input logic eo, input bit push);
    wait_ready();
    in_if.in_valid = 1'b1;
    in_if.in_data  = v;
    if (push) push_exp(eb, eh, eo);
    @(negedge clk);
    in_if.in_valid = 1'b0;
    in_if.in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hex"},   64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(ALL_BLANK));
    chk({tag, "_bcd"},   64'(bcd), 64'd0);
    chk({tag, "_ovf"},   64'(overflow), 64'd0);
    chk({tag, "_ready"}, 64'(in_if.in_ready), 64'd1);
    chk({tag, "_busy"},  64'(busy), 64'd0);
  endtask

  // Monitor: a completed conversion shows as busy falling on a non-reset edge.
  initial begin : monitor
    logic prev_busy;
    logic rst_seen;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      rst_seen = reset;
      @(negedge clk);
      if (!rst_seen && prev_busy && !busy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_update", 64'(bcd), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("bcd",      64'(bcd), 64'(e.bcd));
          chk("hex",      64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(e.hex));
          chk("overflow", 64'(overflow), 64'(e.ovf));
          chk("latency",  64'(cyc), 64'(e.due));
        end
      end
      prev_busy = busy;
    end
  end

  initial begin : driver
    logic rdy;
    int   low_cnt;
    int   n;
    in_if.in_valid = 1'b0;
    in_if.in_data  = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state("reset");

    send(32'd0,       40'h0,          hx(BL, BL, BL, BL, BL, 7'h40), 1'b0, 1'b1);
    send(32'd123456,  40'h123456,     hx(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02), 1'b0, 1'b1);
    send(32'd100005,  40'h100005,     hx(7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12), 1'b0, 1'b1);
    send(32'd1000,    40'h1000,       hx(BL, BL, 7'h79, 7'h40, 7'h40, 7'h40), 1'b0, 1'b1);
    send(32'd999999,  40'h999999,     hx(7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10), 1'b0, 1'b1);
    send(32'd1000000, 40'h0001000000, ALL_DASH, 1'b1, 1'b1);
    send(32'hFFFFFFFF, 40'h4294967295, ALL_DASH, 1'b1, 1'b1);

    // Back-to-back: valid held high with data = cycle offset; only offsets
    // 0, 34 and 68 may be accepted.
    wait_ready();
    low_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      if (k > 0) @(negedge clk);
      rdy = in_if.in_ready;
      if (k >= 1 && k <= 33 && !rdy) low_cnt++;
      in_if.in_valid = 1'b1;
      in_if.in_data  = 32'(k);
      if (rdy) begin
        case (k)
          0:       push_exp(40'h0,  hx(BL, BL, BL, BL, BL, 7'h40), 1'b0);
          34:      push_exp(40'h34, hx(BL, BL, BL, BL, 7'h30, 7'h19), 1'b0);
          68:      push_exp(40'h68, hx(BL, BL, BL, BL, 7'h02, 7'h00), 1'b0);
          default: chk("b2b_accept_offset", 64'(k), 64'hFFFF_FFFF);
        endcase
      end
    end
    @(negedge clk);
    in_if.in_valid = 1'b0;
    chk("b2b_ready_low", 64'(low_cnt), 64'd33);

    // Reset in the middle of a conversion after 42 is on display.
    send(32'd42, 40'h42, hx(BL, BL, BL, BL, 7'h19, 7'h24), 1'b0, 1'b1);
    send(32'd777, 40'h0, ALL_BLANK, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state("abort");
    repeat (40) @(negedge clk);
    chk_reset_state("abort_hold");

    send(32'd7, 40'h7, hx(BL, BL, BL, BL, BL, 7'h78), 1'b0, 1'b1);

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
